// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: RV32I opcodes, one-hot ALU control words and decode record
// shared by the decode stage files.
package decode_stage_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [11:0] C_ADD  = 12'h800;
    localparam logic [11:0] C_PC4  = 12'h400;
    localparam logic [11:0] C_SUB  = 12'h200;
    localparam logic [11:0] C_SLT  = 12'h100;
    localparam logic [11:0] C_SLTU = 12'h080;
    localparam logic [11:0] C_AND  = 12'h040;
    localparam logic [11:0] C_OR   = 12'h020;
    localparam logic [11:0] C_XOR  = 12'h010;
    localparam logic [11:0] C_SLL  = 12'h008;
    localparam logic [11:0] C_SRL  = 12'h004;
    localparam logic [11:0] C_SRA  = 12'h002;
    localparam logic [11:0] C_LUI  = 12'h001;
    typedef struct packed {
        logic [11:0] ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic        rs1_used;
        logic        rs2_used;
    } dec_t;
    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [11:0] alu_sel(input logic [2:0] f3, input logic alt);
        return f3 == 3'b000 ? (alt ? C_SUB : C_ADD) :
               f3 == 3'b001 ? C_SLL :
               f3 == 3'b010 ? C_SLT :
               f3 == 3'b011 ? C_SLTU :
               f3 == 3'b100 ? C_XOR :
               f3 == 3'b101 ? (alt ? C_SRA : C_SRL) :
               f3 == 3'b110 ? C_OR : C_AND;
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, regfile, writeback and EX signals of the decode stage.
// master is the decode stage itself, slave is its surroundings.
interface decode_stage_if;
    logic        i_InstrValid;
    logic [31:0] i_Instr_32;
    logic [31:0] i_PC_32;
    logic        o_InstrReady;
    logic [4:0]  o_Rs1Addr_5;
    logic [4:0]  o_Rs2Addr_5;
    logic [31:0] i_Rs1Data_32;
    logic [31:0] i_Rs2Data_32;
    logic        i_WbRegWrite;
    logic [4:0]  i_WbRd_5;
    logic [31:0] i_WbData_32;
    logic        i_ExLoad;
    logic [4:0]  i_ExRd_5;
    logic        i_Flush;
    logic        i_ExReady;
    logic        o_Valid;
    logic [31:0] o_PC_32;
    logic [11:0] o_ALUControl_12;
    logic [31:0] o_ALUOperand1_32;
    logic [31:0] o_ALUOperand2_32;
    logic [31:0] o_StoreData_32;
    logic [31:0] o_Rs1Val_32;
    logic [4:0]  o_RdAddr_5;
    logic        o_RegWrite;
    logic        o_MemRead;
    logic        o_MemWrite;
    logic        o_Branch;
    logic        o_Jump;
    logic [2:0]  o_Funct3_3;
    logic        o_IllegalInstr;
    modport master(
        input  i_InstrValid, i_Instr_32, i_PC_32, i_Rs1Data_32, i_Rs2Data_32,
               i_WbRegWrite, i_WbRd_5, i_WbData_32, i_ExLoad, i_ExRd_5, i_Flush, i_ExReady,
        output o_InstrReady, o_Rs1Addr_5, o_Rs2Addr_5, o_Valid, o_PC_32, o_ALUControl_12,
               o_ALUOperand1_32, o_ALUOperand2_32, o_StoreData_32, o_Rs1Val_32, o_RdAddr_5,
               o_RegWrite, o_MemRead, o_MemWrite, o_Branch, o_Jump, o_Funct3_3, o_IllegalInstr
    );
    modport slave(
        output i_InstrValid, i_Instr_32, i_PC_32, i_Rs1Data_32, i_Rs2Data_32,
               i_WbRegWrite, i_WbRd_5, i_WbData_32, i_ExLoad, i_ExRd_5, i_Flush, i_ExReady,
        input  o_InstrReady, o_Rs1Addr_5, o_Rs2Addr_5, o_Valid, o_PC_32, o_ALUControl_12,
               o_ALUOperand1_32, o_ALUOperand2_32, o_StoreData_32, o_Rs1Val_32, o_RdAddr_5,
               o_RegWrite, o_MemRead, o_MemWrite, o_Branch, o_Jump, o_Funct3_3, o_IllegalInstr
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// decode_stage_imm_gen: sign-extended I/S/B/U/J immediates of an RV32I word
// (opcode bits are not needed, so only instr[31:7] comes in).
module decode_stage_imm_gen (
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage with load-use interlock and flush.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data onto rs1/rs2.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.master bus
);
    logic [31:0] instr, rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        load_en, hazard, kill;
    dec_t        d;
    assign instr = bus.i_Instr_32;
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign bus.o_Rs1Addr_5 = rs1;
    assign bus.o_Rs2Addr_5 = rs2;
    decode_stage_imm_gen u_imm_gen (
        .instr(instr[31:7]), .imm_i(imm_i), .imm_s(imm_s), .imm_b(imm_b), .imm_u(imm_u), .imm_j(imm_j)
    );
`ifdef DECODE_WB_BYPASS_EN
    assign rs1_val = rs1 == 5'd0 ? '0 : (bus.i_WbRegWrite && bus.i_WbRd_5 == rs1) ? bus.i_WbData_32 : bus.i_Rs1Data_32;
    assign rs2_val = rs2 == 5'd0 ? '0 : (bus.i_WbRegWrite && bus.i_WbRd_5 == rs2) ? bus.i_WbData_32 : bus.i_Rs2Data_32;
`else
    logic unused_wb;
    assign unused_wb = ^{bus.i_WbRegWrite, bus.i_WbRd_5, bus.i_WbData_32};
    assign rs1_val = rs1 == 5'd0 ? '0 : bus.i_Rs1Data_32;
    assign rs2_val = rs2 == 5'd0 ? '0 : bus.i_Rs2Data_32;
`endif
    always_comb begin
        d = '0;
        case (instr[6:0])
            OPC_OP: begin
                d = '{alu_sel(f3, f7[5]), rs1_val, rs2_val, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
                d.illegal = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                d = '{alu_sel(f3, f3 == 3'b101 && f7[5]), rs1_val, imm_i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
                d.illegal = f3 == 3'b001 ? f7 != 7'b0 : f3 == 3'b101 ? (f7 != 7'b0 && f7 != 7'b0100000) : 1'b0;
            end
            OPC_LUI:    d = '{C_LUI, 32'd0, imm_u, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            OPC_AUIPC:  d = '{C_ADD, bus.i_PC_32, imm_u, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            OPC_JAL:    d = '{C_PC4, bus.i_PC_32, imm_j, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            OPC_JALR:   d = '{C_PC4, rs1_val, imm_i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, f3 != 3'b000, 1'b1, 1'b0};
            OPC_BRANCH: d = '{C_ADD, bus.i_PC_32, imm_b, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, f3[2:1] == 2'b01, 1'b1, 1'b1};
            OPC_LOAD:   d = '{C_ADD, rs1_val, imm_i, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, f3 == 3'b011 || f3[2:1] == 2'b11, 1'b1, 1'b0};
            OPC_STORE:  d = '{C_ADD, rs1_val, imm_s, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, f3[2] || f3 == 3'b011, 1'b1, 1'b1};
            default:    d.illegal = 1'b1;
        endcase
        if (d.illegal) {d.ctrl, d.reg_write, d.mem_read, d.mem_write, d.branch, d.jump} = '0;
        if (rd == 5'd0) d.reg_write = 1'b0;
    end
    assign load_en = !bus.o_Valid || bus.i_ExReady;
    assign hazard  = bus.i_InstrValid && bus.i_ExLoad && bus.i_ExRd_5 != 5'd0 &&
                     ((d.rs1_used && rs1 == bus.i_ExRd_5) || (d.rs2_used && rs2 == bus.i_ExRd_5));
    assign kill    = bus.i_Flush || (load_en && (hazard || !bus.i_InstrValid));
    assign bus.o_InstrReady = bus.i_Flush || (load_en && !hazard);
    // Killing clears only the control bits; data fields keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {bus.o_Valid, bus.o_ALUControl_12, bus.o_RegWrite, bus.o_MemRead, bus.o_MemWrite,
             bus.o_Branch, bus.o_Jump, bus.o_IllegalInstr} <= '0;
            {bus.o_ALUOperand1_32, bus.o_ALUOperand2_32, bus.o_StoreData_32, bus.o_Rs1Val_32,
             bus.o_RdAddr_5, bus.o_Funct3_3} <= '0;
            bus.o_PC_32 <= RESET_PC;
        end else if (kill) begin
            {bus.o_Valid, bus.o_ALUControl_12, bus.o_RegWrite, bus.o_MemRead, bus.o_MemWrite,
             bus.o_Branch, bus.o_Jump, bus.o_IllegalInstr} <= '0;
        end else if (load_en) begin
            {bus.o_Valid, bus.o_ALUControl_12, bus.o_RegWrite, bus.o_MemRead, bus.o_MemWrite,
             bus.o_Branch, bus.o_Jump, bus.o_IllegalInstr} <=
                {1'b1, d.ctrl, d.reg_write, d.mem_read, d.mem_write, d.branch, d.jump, d.illegal};
            {bus.o_ALUOperand1_32, bus.o_ALUOperand2_32, bus.o_StoreData_32, bus.o_Rs1Val_32,
             bus.o_RdAddr_5, bus.o_Funct3_3} <= {d.op1, d.op2, rs2_val, rs1_val, rd, f3};
            bus.o_PC_32 <= bus.i_PC_32;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed decode vectors plus stall, load-use, flush and
// mid-stall reset sequences for decode_stage (default build, no WB bypass).
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    decode_stage_if bus();
    decode_stage #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    always #5 clk = ~clk;
    typedef struct packed {
        logic [31:0] instr, pc, r1d, r2d;
        logic [11:0] ctrl;
        logic [31:0] op1, op2, sd, r1v;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, jp, il, chk_ops, chk_rd;
    } vec_t;
    vec_t v[13];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1d, input logic [31:0] r2d);
        bus.i_InstrValid = 1'b1;
        bus.i_Instr_32 = instr;
        bus.i_PC_32 = pc;
        bus.i_Rs1Data_32 = r1d;
        bus.i_Rs2Data_32 = r2d;
    endtask
    initial begin
        v[0]  = '{32'h00500093, 32'h100, 32'hDEAD, 32'h11, 12'h800, 32'h0, 32'h5, 32'h11, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        v[1]  = '{32'h402081B3, 32'h104, 32'h7, 32'h3, 12'h200, 32'h7, 32'h3, 32'h3, 32'h7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        v[2]  = '{32'h008000EF, 32'h200, 32'h22, 32'h22, 12'h400, 32'h200, 32'h8, 32'h22, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        v[3]  = '{32'hFFFFFFFF, 32'h204, 32'h1, 32'h2, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        v[4]  = '{32'h123452B7, 32'h208, 32'h33, 32'h44, 12'h001, 32'h0, 32'h12345000, 32'h44, 32'h33, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        v[5]  = '{32'h00001317, 32'h300, 32'h55, 32'h55, 12'h800, 32'h300, 32'h1000, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        v[6]  = '{32'hFFC12383, 32'h304, 32'h1000, 32'h66, 12'h800, 32'h1000, 32'hFFFFFFFC, 32'h66, 32'h1000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        v[7]  = '{32'h0030A423, 32'h308, 32'h2000, 32'h55, 12'h800, 32'h2000, 32'h8, 32'h55, 32'h2000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        v[8]  = '{32'hFE208CE3, 32'h400, 32'h9, 32'h9, 12'h800, 32'h400, 32'hFFFFFFF8, 32'h9, 32'h9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        v[9]  = '{32'h4034D413, 32'h404, 32'h80000000, 32'h77, 12'h002, 32'h80000000, 32'h403, 32'h77, 32'h80000000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        v[10] = '{32'h00000233, 32'h408, 32'hFFFF, 32'hFFFF, 12'h800, 32'h0, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        v[11] = '{32'h00100013, 32'h40C, 32'h99, 32'h88, 12'h800, 32'h0, 32'h1, 32'h88, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        v[12] = '{32'h022080B3, 32'h410, 32'h1, 32'h2, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.i_InstrValid = 1'b0; bus.i_Instr_32 = '0; bus.i_PC_32 = '0;
        bus.i_Rs1Data_32 = '0; bus.i_Rs2Data_32 = '0;
        bus.i_WbRegWrite = 1'b0; bus.i_WbRd_5 = '0; bus.i_WbData_32 = '0;
        bus.i_ExLoad = 1'b0; bus.i_ExRd_5 = '0; bus.i_Flush = 1'b0; bus.i_ExReady = 1'b1;
        step(); step();
        chk("reset valid", 32'(bus.o_Valid), 32'd0);
        chk("reset pc", bus.o_PC_32, 32'h0);
        chk("reset ctrl", 32'(bus.o_ALUControl_12), 32'h0);
        chk("reset op1", bus.o_ALUOperand1_32, 32'h0);
        rst = 1'b0;
        #1;
        chk("idle ready", 32'(bus.o_InstrReady), 32'd1);
        for (int i = 0; i < 13; i++) begin
            drive(v[i].instr, v[i].pc, v[i].r1d, v[i].r2d);
            #1;
            chk($sformatf("v%0d ready", i), 32'(bus.o_InstrReady), 32'd1);
            chk($sformatf("v%0d rs1addr", i), 32'(bus.o_Rs1Addr_5), 32'(v[i].instr[19:15]));
            step();
            chk($sformatf("v%0d valid", i), 32'(bus.o_Valid), 32'd1);
            chk($sformatf("v%0d pc", i), bus.o_PC_32, v[i].pc);
            chk($sformatf("v%0d ctrl", i), 32'(bus.o_ALUControl_12), 32'(v[i].ctrl));
            chk($sformatf("v%0d flags", i), 32'({bus.o_RegWrite, bus.o_MemRead, bus.o_MemWrite, bus.o_Branch, bus.o_Jump, bus.o_IllegalInstr}),
                32'({v[i].rw, v[i].mr, v[i].mw, v[i].br, v[i].jp, v[i].il}));
            if (v[i].chk_rd) chk($sformatf("v%0d rd", i), 32'(bus.o_RdAddr_5), 32'(v[i].rd));
            if (v[i].chk_ops) begin
                chk($sformatf("v%0d op1", i), bus.o_ALUOperand1_32, v[i].op1);
                chk($sformatf("v%0d op2", i), bus.o_ALUOperand2_32, v[i].op2);
                chk($sformatf("v%0d storedata", i), bus.o_StoreData_32, v[i].sd);
                chk($sformatf("v%0d rs1val", i), bus.o_Rs1Val_32, v[i].r1v);
            end
        end
        // EX back-pressure: ADDI held for three cycles while SUB waits
        drive(32'h00500093, 32'h500, 32'h0, 32'h0);
        step();
        drive(32'h402081B3, 32'h504, 32'h7, 32'h3);
        bus.i_ExReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall ready", 32'(bus.o_InstrReady), 32'd0);
            step();
            chk("stall valid", 32'(bus.o_Valid), 32'd1);
            chk("stall ctrl", 32'(bus.o_ALUControl_12), 32'h800);
            chk("stall op2", bus.o_ALUOperand2_32, 32'h5);
            chk("stall pc", bus.o_PC_32, 32'h500);
        end
        bus.i_ExReady = 1'b1;
        #1;
        chk("release ready", 32'(bus.o_InstrReady), 32'd1);
        step();
        chk("release ctrl", 32'(bus.o_ALUControl_12), 32'h200);
        chk("release op1", bus.o_ALUOperand1_32, 32'h7);
        chk("release pc", bus.o_PC_32, 32'h504);
        // load-use interlock on ADD x4,x1,x2
        drive(32'h00208233, 32'h600, 32'h10, 32'h20);
        bus.i_ExLoad = 1'b1; bus.i_ExRd_5 = 5'd1;
        #1;
        chk("hazard ready", 32'(bus.o_InstrReady), 32'd0);
        step();
        chk("bubble valid", 32'(bus.o_Valid), 32'd0);
        chk("bubble ctrl", 32'(bus.o_ALUControl_12), 32'h0);
        chk("bubble regwrite", 32'(bus.o_RegWrite), 32'd0);
        bus.i_ExRd_5 = 5'd3;
        #1;
        chk("unrelated load ready", 32'(bus.o_InstrReady), 32'd1);
        bus.i_ExRd_5 = 5'd2;
        #1;
        chk("rs2 hazard ready", 32'(bus.o_InstrReady), 32'd0);
        bus.i_ExLoad = 1'b0;
        #1;
        chk("no load ready", 32'(bus.o_InstrReady), 32'd1);
        step();
        chk("after bubble valid", 32'(bus.o_Valid), 32'd1);
        chk("after bubble ctrl", 32'(bus.o_ALUControl_12), 32'h800);
        chk("after bubble rd", 32'(bus.o_RdAddr_5), 32'd4);
        chk("after bubble op2", bus.o_ALUOperand2_32, 32'h20);
        // flush overrides both EX stall and a pending hazard
        bus.i_ExReady = 1'b0; bus.i_ExLoad = 1'b1; bus.i_ExRd_5 = 5'd1; bus.i_Flush = 1'b1;
        #1;
        chk("flush ready", 32'(bus.o_InstrReady), 32'd1);
        step();
        chk("flush valid", 32'(bus.o_Valid), 32'd0);
        chk("flush ctrl", 32'(bus.o_ALUControl_12), 32'h0);
        bus.i_Flush = 1'b0; bus.i_ExLoad = 1'b0; bus.i_ExReady = 1'b1;
        // no valid instruction: output goes empty
        drive(32'h00500093, 32'h700, 32'h0, 32'h0);
        step();
        chk("refill valid", 32'(bus.o_Valid), 32'd1);
        bus.i_InstrValid = 1'b0;
        step();
        chk("empty valid", 32'(bus.o_Valid), 32'd0);
        chk("empty ctrl", 32'(bus.o_ALUControl_12), 32'h0);
        // asynchronous reset while stalled
        drive(32'h123452B7, 32'h800, 32'h0, 32'h0);
        step();
        bus.i_ExReady = 1'b0;
        step();
        chk("prereset valid", 32'(bus.o_Valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst valid", 32'(bus.o_Valid), 32'd0);
        chk("async rst ctrl", 32'(bus.o_ALUControl_12), 32'h0);
        chk("async rst pc", bus.o_PC_32, 32'h0);
        chk("async rst op2", bus.o_ALUOperand2_32, 32'h0);
        chk("async rst regwrite", 32'(bus.o_RegWrite), 32'd0);
        step();
        rst = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
